// File: rtl/flag_unit.sv
// flag_unit: N/V/Z flag register and flag-hazard stall/bypass for the branch path.
// Ports: clk, rst (async, high); ex_* = EX-stage instruction, result and overflow;
//   id_branch/id_cond = branch in decode; F = {N,V,Z} to PC control;
//   flag_stall = hold front end; stall_count = saturating stall-cycle count.
// Optional macro FLAG_BYPASS_EN: forward next flags to F instead of stalling.
module flag_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_flush,
  input  logic             ex_hold,
  input  logic [3:0]       ex_opcode,
  input  logic [15:0]      ex_result,
  input  logic             ex_ovfl,
  input  logic             id_branch,
  input  logic [2:0]       id_cond,
  output logic [2:0]       F,
  output logic             flag_stall,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       flg_q, flg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       wr_all, wr_z;
  logic       sx, need, hz, upd, res_z;
  logic [2:0] flg_nxt;

  always_comb begin
    wr_all = 1'b0;
    wr_z   = 1'b0;
    unique case (ex_opcode)
      OP_ADD, OP_SUB: wr_all = 1'b1;
      OP_XOR, OP_SLL,
      OP_SRA, OP_ROR: wr_z   = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    res_z = ~|ex_result;
    sx    = ex_valid & ~ex_flush & (wr_all | wr_z);
    need  = id_branch & (id_cond != 3'b111);
    hz    = sx & need;
    upd   = ex_valid & ~ex_flush & ~ex_hold;

    // Z-only ops keep N and V from the register.
    flg_nxt = flg_q;
    if (wr_all) begin
      flg_nxt = {ex_result[15], ex_ovfl, res_z};
    end else if (wr_z) begin
      flg_nxt[0] = res_z;
    end

    flg_d = upd ? flg_nxt : flg_q;
  end

`ifdef FLAG_BYPASS_EN
  always_comb begin
    flag_stall = 1'b0;
    F          = hz ? flg_nxt : flg_q;
  end
`else
  always_comb begin
    flag_stall = hz;
    F          = flg_q;
  end
`endif

  // Held cycles repeat the same stall, so they are not counted.
  always_comb begin
    cnt_d = cnt_q;
    if (flag_stall & ~ex_hold & ~&cnt_q) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flg_q <= 3'b000;
      cnt_q <= '0;
    end else begin
      flg_q <= flg_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: randomized and directed checks of flag_unit
// against a behavioural flag/stall model.
module tb_flag_unit;

  localparam int SMAX = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_flush, ex_hold;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_result;
  logic        ex_ovfl, id_branch;
  logic [2:0]  id_cond;
  logic [2:0]  F, F_s;
  logic        flag_stall, flag_stall_s;
  logic [15:0] stall_count;
  logic [2:0]  stall_count_s;

  int vectors = 0;
  int errors  = 0;

  logic [2:0] m_f;
  int         m_cnt, m_cnt_s;

  flag_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_flush(ex_flush),
    .ex_hold(ex_hold), .ex_opcode(ex_opcode),
    .ex_result(ex_result), .ex_ovfl(ex_ovfl),
    .id_branch(id_branch), .id_cond(id_cond),
    .F(F), .flag_stall(flag_stall),
    .stall_count(stall_count)
  );

  flag_unit #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_flush(ex_flush),
    .ex_hold(ex_hold), .ex_opcode(ex_opcode),
    .ex_result(ex_result), .ex_ovfl(ex_ovfl),
    .id_branch(id_branch), .id_cond(id_cond),
    .F(F_s), .flag_stall(flag_stall_s),
    .stall_count(stall_count_s)
  );

  always #5 clk = ~clk;

  function automatic logic is_full(input logic [3:0] op);
    return op == 4'd0 || op == 4'd1;
  endfunction

  function automatic logic is_zonly(input logic [3:0] op);
    return op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6;
  endfunction

  function automatic logic [2:0] nxt_flags();
    logic [2:0] r;
    r = m_f;
    if (is_full(ex_opcode))
      r = {ex_result[15], ex_ovfl, ex_result == 16'h0};
    else if (is_zonly(ex_opcode))
      r[0] = (ex_result == 16'h0);
    return r;
  endfunction

  function automatic logic haz();
    return ex_valid && !ex_flush
      && (is_full(ex_opcode) || is_zonly(ex_opcode))
      && id_branch && id_cond != 3'b111;
  endfunction

  function automatic logic exp_stall();
`ifdef FLAG_BYPASS_EN
    return 1'b0;
`else
    return haz();
`endif
  endfunction

  function automatic logic [2:0] exp_f();
`ifdef FLAG_BYPASS_EN
    return haz() ? nxt_flags() : m_f;
`else
    return m_f;
`endif
  endfunction

  task automatic drive(input logic v, input logic fl,
                       input logic h, input logic [3:0] op,
                       input logic [15:0] res, input logic ov,
                       input logic br, input logic [2:0] c);
    ex_valid = v; ex_flush = fl; ex_hold = h;
    ex_opcode = op; ex_result = res; ex_ovfl = ov;
    id_branch = br; id_cond = c;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 4'hF, 16'h0, 0, 0, 3'b000);
  endtask

  // Advance one clock edge and update the model.
  task automatic tick();
    logic [2:0] nf;
    logic       st, up;
    nf = nxt_flags();
    st = exp_stall();
    up = ex_valid && !ex_flush && !ex_hold;
    @(posedge clk);
    if (rst) begin
      m_f = 3'b000; m_cnt = 0; m_cnt_s = 0;
    end else begin
      if (up) m_f = nf;
      if (st && !ex_hold) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < SMAX) m_cnt_s++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive($urandom, $urandom, $urandom, 4'($urandom),
          16'($urandom), $urandom, $urandom, 3'($urandom));
    m_f = 3'b000; m_cnt = 0; m_cnt_s = 0;
    vectors++;
    if (F !== 3'b000 || stall_count !== 16'h0
        || stall_count_s !== 3'h0) begin
      errors++;
      $display("FAIL reset: F=%b cnt=%h cnt_s=%h want 000/0/0",
               F, stall_count, stall_count_s);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
  endtask

  task automatic test_nv_z();
    drive(1, 0, 0, 4'b0001, 16'h0000, 0, 0, 3'b000);
    tick(); idle();
    vectors++;
    if (F !== 3'b001) begin
      errors++;
      $display("FAIL sub_zero: F=%b want 001", F);
    end
    drive(1, 0, 0, 4'b0000, 16'h8000, 1, 0, 3'b000);
    tick(); idle();
    vectors++;
    if (F !== 3'b110) begin
      errors++;
      $display("FAIL add_neg_ovf: F=%b want 110", F);
    end
  endtask

  task automatic test_z_only();
    logic [3:0] ops [3];
    ops[0] = 4'b1000; ops[1] = 4'b0011; ops[2] = 4'b0111;
    drive(1, 0, 0, 4'b0010, 16'h0000, 0, 0, 3'b000);
    tick(); idle();
    vectors++;
    if (F !== 3'b111) begin
      errors++;
      $display("FAIL xor_zonly: F=%b want 111", F);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, ops[i], 16'h1234, 0, 1, 3'b001);
      vectors++;
      if (flag_stall !== 1'b0) begin
        errors++;
        $display("FAIL nonsetter_stall op=%b: got %b want 0",
                 ops[i], flag_stall);
      end
      tick(); idle();
      vectors++;
      if (F !== 3'b111) begin
        errors++;
        $display("FAIL nonsetter op=%b: F=%b want 111",
                 ops[i], F);
      end
    end
  endtask

  task automatic test_hazard();
    int c0;
    drive(1, 0, 0, 4'b0000, 16'h0001, 0, 0, 3'b000);
    tick(); idle();
    c0 = m_cnt;
    drive(1, 0, 0, 4'b0001, 16'h0000, 0, 1, 3'b001);
    vectors++;
    if (flag_stall !== exp_stall() || F !== exp_f()) begin
      errors++;
      $display("FAIL hazard_cycle: stall=%b F=%b want %b/%b",
               flag_stall, F, exp_stall(), exp_f());
    end
    tick();
    drive(0, 0, 0, 4'b0000, 16'h0000, 0, 1, 3'b001);
    vectors++;
    if (flag_stall !== 1'b0 || F !== 3'b001
        || stall_count !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL hazard_after: stall=%b F=%b cnt=%0d want 0/001/%0d",
               flag_stall, F, stall_count, m_cnt);
    end
`ifndef FLAG_BYPASS_EN
    vectors++;
    if (m_cnt != c0 + 1) begin
      errors++;
      $display("FAIL hazard_count: model cnt=%0d want %0d",
               m_cnt, c0 + 1);
    end
`endif
    drive(1, 0, 0, 4'b0001, 16'h0000, 0, 1, 3'b111);
    vectors++;
    if (flag_stall !== 1'b0 || F !== 3'b001) begin
      errors++;
      $display("FAIL uncond_nostall: stall=%b F=%b want 0/001",
               flag_stall, F);
    end
    tick(); idle();
  endtask

  task automatic test_bypass_cycle();
    drive(1, 0, 0, 4'b0001, 16'hFFFF, 0, 1, 3'b011);
`ifdef FLAG_BYPASS_EN
    vectors++;
    if (F !== 3'b100 || flag_stall !== 1'b0) begin
      errors++;
      $display("FAIL bypass: F=%b stall=%b want 100/0",
               F, flag_stall);
    end
`else
    vectors++;
    if (F !== m_f || flag_stall !== 1'b1) begin
      errors++;
      $display("FAIL nobypass: F=%b stall=%b want %b/1",
               F, flag_stall, m_f);
    end
`endif
    tick(); idle();
    vectors++;
    if (F !== 3'b100) begin
      errors++;
      $display("FAIL sub_ffff: F=%b want 100", F);
    end
  endtask

  task automatic test_flush_hold();
    logic [2:0] f0;
    int         c0;
    drive(1, 0, 0, 4'b0010, 16'h0000, 0, 0, 3'b000);
    tick();
    f0 = m_f;
    drive(1, 1, 0, 4'b0000, 16'h0005, 0, 1, 3'b010);
    vectors++;
    if (flag_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %b want 0", flag_stall);
    end
    tick(); idle();
    vectors++;
    if (F !== f0) begin
      errors++;
      $display("FAIL flush_noupd: F=%b want %b", F, f0);
    end
    c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 4'b0000, 16'h0005, 0, 1, 3'b010);
      vectors++;
      if (flag_stall !== exp_stall()) begin
        errors++;
        $display("FAIL hold_stall %0d: got %b want %b",
                 i, flag_stall, exp_stall());
      end
      tick();
      vectors++;
      if (F !== f0 || stall_count !== 16'(c0)) begin
        errors++;
        $display("FAIL hold %0d: F=%b cnt=%0d want %b/%0d",
                 i, F, stall_count, f0, c0);
      end
    end
    drive(1, 0, 0, 4'b0000, 16'h0005, 0, 0, 3'b000);
    tick(); idle();
    vectors++;
    if (F !== 3'b000) begin
      errors++;
      $display("FAIL hold_release: F=%b want 000", F);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 4'b0100, 16'(i), 0, 1, 3'b000);
      tick();
    end
    idle();
    vectors++;
    if (stall_count_s !== 3'(m_cnt_s)
        || stall_count !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL saturate: cnt_s=%0d cnt=%0d want %0d/%0d",
               stall_count_s, stall_count, m_cnt_s, m_cnt);
    end
`ifndef FLAG_BYPASS_EN
    vectors++;
    if (stall_count_s !== 3'd7) begin
      errors++;
      $display("FAIL sat_max: cnt_s=%0d want 7", stall_count_s);
    end
`endif
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 0, 0, 4'b0000, 16'h8000, 1, 0, 3'b000);
    tick();
    drive(1, 0, 0, 4'b0001, 16'h0000, 0, 1, 3'b001);
    #2;
    rst = 1'b1;
    m_f = 3'b000; m_cnt = 0; m_cnt_s = 0;
    #1;
    vectors++;
    if (F !== exp_f() || stall_count !== 16'h0
        || stall_count_s !== 3'h0 || flag_stall !== exp_stall()) begin
      errors++;
      $display("FAIL reset_mid: F=%b cnt=%0d stall=%b want %b/0/%b",
               F, stall_count, flag_stall, exp_f(), exp_stall());
    end
    tick();
    rst = 1'b0;
    idle();
    vectors++;
    if (flag_stall !== 1'b0 || F !== 3'b000) begin
      errors++;
      $display("FAIL reset_clear: stall=%b F=%b want 0/000",
               flag_stall, F);
    end
  endtask

  task automatic test_random();
    logic [15:0] r;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
      drive($urandom_range(0, 9) < 8,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0,
            4'($urandom), r, 1'($urandom),
            1'($urandom), 3'($urandom));
      vectors++;
      if (F !== exp_f() || flag_stall !== exp_stall()
          || stall_count !== 16'(m_cnt)
          || stall_count_s !== 3'(m_cnt_s)) begin
        errors++;
        $display("FAIL random %0d: F=%b st=%b c=%0d cs=%0d want %b/%b/%0d/%0d",
                 i, F, flag_stall, stall_count, stall_count_s,
                 exp_f(), exp_stall(), m_cnt, m_cnt_s);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_nv_z();
    test_z_only();
    test_hazard();
    test_bypass_cycle();
    test_flush_hold();
    test_saturate();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
